// File: rtl/spi_mem_sched_pkg.sv
// rtl/spi_mem_sched_pkg.sv - shared states, SPI command opcodes and frame geometry
package spi_mem_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRAME1,
    S_GAP1,
    S_FRAME2,
    S_DONE
  } sched_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Cycles in an address frame or a write-data frame: start, command, word, commit.
  function automatic int frame_len(input int aw);
    return aw + 5;
  endfunction

  // The read-data frame keeps SS_n low long enough for the slave to shift data back.
  function automatic int rd_frame_len(input int aw);
    return 2 * aw + 6;
  endfunction

  // Frame cycle index carrying the word LSB.
  function automatic int last_bit_k(input int aw);
    return aw + 3;
  endfunction

  // MISO is sampled at the edges that end these frame cycles, MSB first.
  function automatic int cap_first_k(input int aw);
    return aw + 6;
  endfunction

  function automatic int cap_last_k(input int aw);
    return 2 * aw + 5;
  endfunction

endpackage

// File: rtl/spi_mem_sched_rr_arbiter.sv
// rtl/spi_mem_sched_rr_arbiter.sv - combinational round-robin arbiter, one-hot grant
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  logic [NUM_REQ-1:0] w_mask_hi;
  logic [NUM_REQ-1:0] w_req_hi;
  logic [NUM_REQ-1:0] w_sel;

  // Requesters strictly after the pointer get first chance; wrap to the full set otherwise.
  always_comb begin
    w_mask_hi = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask_hi[i] = (PW'(i) > i_ptr);
    end
  end

  assign w_req_hi = i_req & w_mask_hi;
  assign w_sel    = (|w_req_hi) ? w_req_hi : i_req;
  // Isolate the lowest set bit of the chosen candidate set.
  assign o_grant  = w_sel & (~w_sel + 1'b1);

endmodule

// File: rtl/spi_mem_sched.sv
// rtl/spi_mem_sched.sv - round-robin scheduler issuing atomic two-frame SPI memory transactions
module spi_mem_sched
  import spi_mem_sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_rw,
  input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
  input  logic [NUM_REQ*ADDR_SIZE-1:0] req_wdata,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [ADDR_SIZE-1:0]         rsp_rdata,
  output logic                         busy,
  output logic                         MOSI,
  output logic                         SS_n,
  input  logic                         MISO
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int FW = ADDR_SIZE + 2;

  localparam logic [4:0] LP_K_LAST_BIT  = 5'(last_bit_k(ADDR_SIZE));
  localparam logic [4:0] LP_K_END_SHORT = 5'(frame_len(ADDR_SIZE) - 1);
  localparam logic [4:0] LP_K_END_RD    = 5'(rd_frame_len(ADDR_SIZE) - 1);
  localparam logic [4:0] LP_K_CAP_FIRST = 5'(cap_first_k(ADDR_SIZE));
  localparam logic [4:0] LP_K_CAP_LAST  = 5'(cap_last_k(ADDR_SIZE));

  sched_state_e         r_state;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_id;
  logic                 r_rw;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [ADDR_SIZE-1:0] r_wdata;
  logic [ADDR_SIZE-1:0] r_shift;
  logic [4:0]           r_k;
  logic                 r_ss_n;
  logic                 r_mosi;
  logic                 r_rsp_valid;
  logic [IW-1:0]        r_rsp_id;
  logic [ADDR_SIZE-1:0] r_rsp_rdata;
  logic                 r_busy;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IW-1:0]        w_gidx;
  logic                 w_grw;
  logic [ADDR_SIZE-1:0] w_gaddr;
  logic [ADDR_SIZE-1:0] w_gwdata;
  logic [FW-1:0]        w_word1;
  logic [FW-1:0]        w_word2;
  logic [4:0]           w_k_next;
  logic [4:0]           w_k_end2;
  logic                 w_in_cap;
  logic [ADDR_SIZE-1:0] w_cap;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (IW)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Select the granted requester's fields from the packed request buses.
  always_comb begin
    w_gidx   = '0;
    w_grw    = 1'b0;
    w_gaddr  = '0;
    w_gwdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gidx   = IW'(i);
        w_grw    = req_rw[i];
        w_gaddr  = req_addr[i*ADDR_SIZE +: ADDR_SIZE];
        w_gwdata = req_wdata[i*ADDR_SIZE +: ADDR_SIZE];
      end
    end
  end

  // Grants are only offered while idle so a transaction's two frames stay back to back.
  assign req_ready = (r_state == S_IDLE) ? w_grant : '0;

  assign w_word1  = {(r_rw ? CMD_RD_ADDR : CMD_WR_ADDR), r_addr};
  assign w_word2  = r_rw ? {CMD_RD_DATA, {ADDR_SIZE{1'b0}}} : {CMD_WR_DATA, r_wdata};
  assign w_k_next = r_k + 5'd1;
  assign w_k_end2 = r_rw ? LP_K_END_RD : LP_K_END_SHORT;
  assign w_in_cap = r_rw && (r_k >= LP_K_CAP_FIRST) && (r_k <= LP_K_CAP_LAST);
  assign w_cap    = {r_shift[ADDR_SIZE-2:0], MISO};

  // MOSI for frame cycle k: start 0, command bit, word MSB..LSB, then 0 for commit and beyond.
  function automatic logic frame_bit(input logic [FW-1:0] word, input logic [4:0] k);
    logic [FW-1:0] shifted;
    logic          b;
    b       = 1'b0;
    shifted = word >> (LP_K_LAST_BIT - k);
    if (k == 5'd1) begin
      b = word[FW-1];
    end else if ((k >= 5'd2) && (k <= LP_K_LAST_BIT)) begin
      b = shifted[0];
    end
    return b;
  endfunction

  // Sequencer: arbitration, frame generation, MISO capture and response; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= IW'(NUM_REQ - 1);
      r_id        <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_shift     <= '0;
      r_k         <= '0;
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_grant) begin
            r_ptr   <= w_gidx;
            r_id    <= w_gidx;
            r_rw    <= w_grw;
            r_addr  <= w_gaddr;
            r_wdata <= w_gwdata;
            r_k     <= '0;
            r_ss_n  <= 1'b0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_FRAME1;
          end
        end
        S_FRAME1: begin
          if (r_k == LP_K_END_SHORT) begin
            r_ss_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= S_GAP1;
          end else begin
            r_k    <= w_k_next;
            r_mosi <= frame_bit(w_word1, w_k_next);
          end
        end
        S_GAP1: begin
          r_k     <= '0;
          r_shift <= '0;
          r_ss_n  <= 1'b0;
          r_mosi  <= 1'b0;
          r_state <= S_FRAME2;
        end
        S_FRAME2: begin
          if (w_in_cap) begin
            r_shift <= w_cap;
          end
          if (r_k == w_k_end2) begin
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_rdata <= r_rw ? w_cap : '0;
            r_state     <= S_DONE;
          end else begin
            r_k    <= w_k_next;
            r_mosi <= frame_bit(w_word2, w_k_next);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ss_n  <= 1'b1;
          r_mosi  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = r_busy;
  assign MOSI      = r_mosi;
  assign SS_n      = r_ss_n;

endmodule

// File: tb/tb_spi_mem_sched.sv
// tb/tb_spi_mem_sched.sv - scoreboard bench with SPI slave memory model for spi_mem_sched
module tb_spi_mem_sched;

  localparam int NR = 2;
  localparam int AW = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0]          req_rw;
  logic [NR*AW-1:0]       req_addr;
  logic [NR*AW-1:0]       req_wdata;
  logic                   rsp_valid;
  logic [$clog2(NR)-1:0]  rsp_id;
  logic [AW-1:0]          rsp_rdata;
  logic                   busy;
  logic                   MOSI;
  logic                   SS_n;
  logic                   MISO = 1'b0;

  spi_mem_sched #(.NUM_REQ(NR), .ADDR_SIZE(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .MOSI      (MOSI),
    .SS_n      (SS_n),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  typedef struct { bit rw; logic [7:0] addr; logic [7:0] wdata; } op_t;
  typedef struct { logic [12:0] bits; int len; } frm_t;
  typedef struct { int id; logic [7:0] rdata; int lat; } rsp_t;

  op_t  opq[NR][$];
  frm_t exp_frm[$];
  rsp_t exp_rsp[$];
  int   exp_grant[$];
  int   acc_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rsp_seen = 0;

  // slave model state
  int         sk = 0;
  bit         in_frm = 0;
  bit         rd_frm = 0;
  logic [12:0] sh = '0;
  int         hi_cnt = 100;
  int         frm_no = 0;
  logic [7:0] mem [256];
  logic [7:0] wa = '0;
  logic [7:0] ra = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push_frames(input bit rw, input logic [7:0] addr, input logic [7:0] wdata, input bit both);
    logic [9:0] w;
    frm_t f;
    w = {rw, 1'b0, addr};
    f.bits = {1'b0, w[9], w, 1'b0};
    f.len = 13;
    exp_frm.push_back(f);
    if (both) begin
      w = rw ? {2'b11, 8'h00} : {2'b01, wdata};
      f.bits = {1'b0, w[9], w, 1'b0};
      f.len = rw ? 22 : 13;
      exp_frm.push_back(f);
    end
  endtask

  task automatic push_op(input int id, input bit rw, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdata);
    op_t o;
    rsp_t r;
    o.rw = rw; o.addr = addr; o.wdata = wdata;
    opq[id].push_back(o);
    exp_grant.push_back(id);
    push_frames(rw, addr, wdata, 1'b1);
    r.id = id;
    r.rdata = rw ? rdata : 8'h00;
    r.lat = rw ? 37 : 28;
    exp_rsp.push_back(r);
  endtask

  task automatic load(input int i);
    op_t o;
    if (opq[i].size() > 0) begin
      o = opq[i].pop_front();
      req_rw[i] = o.rw;
      req_addr[i*AW +: AW] = o.addr;
      req_wdata[i*AW +: AW] = o.wdata;
      req_valid[i] = 1'b1;
    end else begin
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic run(input int budget);
    logic [NR-1:0] acc;
    int t;
    for (int i = 0; i < NR; i++) load(i);
    t = 0;
    while (((req_valid != '0) || busy) && (t < budget)) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      t++;
      for (int i = 0; i < NR; i++) if (acc[i]) load(i);
    end
    check("run_done", t < budget, 1);
    req_valid = '0;
  endtask

  // Monitors: accept/grant order, responses with latency, and the SPI slave memory.
  always @(negedge clk) begin
    int gidx;
    int lat;
    rsp_t e;
    frm_t f;
    logic [9:0] w;
    logic [7:0] d;
    if (rst) begin
      acc_q.delete();
      in_frm = 0;
      frm_no = 0;
      hi_cnt = 100;
      MISO = 1'b0;
    end else begin
      if ((req_valid & req_ready) != '0) begin
        check("accept_onehot", $onehot(req_valid & req_ready), 1);
        gidx = 0;
        for (int i = 0; i < NR; i++) if (req_ready[i]) gidx = i;
        if (exp_grant.size() == 0) check("grant_unexpected", gidx, 32'hFFFF_FFFF);
        else check("grant_id", gidx, exp_grant.pop_front());
        acc_q.push_back(cyc);
      end
      if (rsp_valid) begin
        rsp_seen++;
        if (exp_rsp.size() == 0) begin
          check("rsp_unexpected", rsp_id, 32'hFFFF_FFFF);
        end else begin
          e = exp_rsp.pop_front();
          lat = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
          check("rsp_id", rsp_id, e.id);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_latency", lat, e.lat);
        end
      end
      if (!SS_n) begin
        if (!in_frm) begin
          in_frm = 1; sk = 0; sh = '0; rd_frm = 0;
          if (frm_no % 2 == 1) check("gap_in_txn", hi_cnt, 1);
          else check("gap_between_txn", hi_cnt >= 2, 1);
        end
        if (sk < 13) sh = {sh[11:0], MOSI};
        if (sk == 3) rd_frm = (sh[1:0] == 2'b11);
        if (rd_frm && sk >= 14 && sk <= 21) begin
          d = mem[ra];
          MISO = d[21 - sk];
        end else begin
          MISO = 1'b0;
        end
        sk++;
      end else begin
        MISO = 1'b0;
        if (in_frm) begin
          in_frm = 0;
          if (exp_frm.size() == 0) begin
            check("frame_unexpected", sh, 32'hFFFF_FFFF);
          end else begin
            f = exp_frm.pop_front();
            check("frame_bits", sh, f.bits);
            check("frame_len", sk, f.len);
          end
          w = sh[10:1];
          case (w[9:8])
            2'b00: wa = w[7:0];
            2'b01: mem[wa] = w[7:0];
            2'b10: ra = w[7:0];
            default: ;
          endcase
          frm_no++;
          hi_cnt = 0;
        end
        hi_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int acc_c;
    int seen;
    rst = 1'b1; req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n", SS_n, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    // single write then read back
    push_op(0, 1'b0, 8'h12, 8'hA5, 8'h00);
    run(2000);
    push_op(1, 1'b1, 8'h12, 8'h00, 8'hA5);
    run(2000);

    // both requesters saturated: grants alternate starting with 0
    for (int j = 0; j < 4; j++) begin
      push_op(0, 1'b0, 8'(8'h40 + j), 8'(8'h10 + j), 8'h00);
      push_op(1, 1'b0, 8'(8'h50 + j), 8'(8'h20 + j), 8'h00);
    end
    run(4000);

    // boundary addresses/data, plus readback of an alternating-phase write
    push_op(0, 1'b0, 8'h00, 8'hFF, 8'h00);
    push_op(1, 1'b0, 8'hFF, 8'h00, 8'h00);
    push_op(0, 1'b1, 8'h00, 8'h00, 8'hFF);
    push_op(1, 1'b1, 8'hFF, 8'h00, 8'h00);
    push_op(0, 1'b1, 8'h53, 8'h00, 8'h23);
    run(4000);

    // reset during read frame 2 at k=16
    exp_grant.push_back(0);
    push_frames(1'b1, 8'h00, 8'h00, 1'b0);
    req_rw[0] = 1'b1; req_addr[0 +: AW] = 8'h00; req_valid[0] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[0] && t < 50);
    check("abort_accept", req_ready[0], 1);
    acc_c = cyc;
    @(posedge clk);
    #1;
    req_valid = '0;
    while (cyc < acc_c + 31) begin
      @(posedge clk);
      #1;
    end
    check("abort_pre_ss_low", SS_n, 0);
    seen = rsp_seen;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ss_n", SS_n, 1);
    check("abort_mosi", MOSI, 0);
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    check("abort_no_rsp", rsp_seen - seen, 0);

    // post-reset: pointer back to NUM_REQ-1 so requester 0 wins first
    push_op(0, 1'b0, 8'h33, 8'h5C, 8'h00);
    push_op(1, 1'b1, 8'h33, 8'h00, 8'h5C);
    run(2000);

    repeat (5) @(posedge clk);
    #1;
    check("left_rsp", exp_rsp.size(), 0);
    check("left_frames", exp_frm.size(), 0);
    check("left_grants", exp_grant.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
